fir4_channel_scheduler: RTL and testbench
=========================================

FIR4_CHANNEL_SCHEDULER -- requirements
Module: fir4_channel_scheduler

Interface
REQ-001 Parameter W, default 16, sample width in bits.
REQ-002 Parameter NCH, default 4, number of input channels sharing the filter.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  clears all channel histories and aborts the in-flight operation.
REQ-006 in_valid  input  NCH  per-channel sample-present flags.
REQ-007 in_data  input  NCH x W  per-channel unsigned samples.
REQ-008 in_ready  output  NCH  per-channel accept strobe; at most one bit set per cycle.
REQ-009 out_valid  output  1  filtered result present.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  W+2  4-tap moving sum for the serviced channel.
REQ-012 out_ch  output  clog2(NCH)  index of the channel that produced out_data.

Function
REQ-013 The block SHALL keep, per channel, a 3-deep history of the previously accepted samples (h1 newest, h3 oldest), all reset to 0.
REQ-014 FSM states SHALL be IDLE, SUM, OUT. Reset state is IDLE.
REQ-015 IDLE: in_ready SHALL be asserted for exactly the granted channel, and only when that channel's in_valid is high. All other in_ready bits are low.
REQ-016 Grant SHALL be round-robin: the first channel with in_valid high, searching upward from pointer p with wrap-around from NCH-1 to 0. After reset, p = 0.
REQ-017 On accept of sample x from channel k, the block SHALL:
- latch x and k;
- compute pairs P1 = x + h1[k] and P2 = h2[k] + h3[k] into W+1-bit registers;
- shift k's history (h3<=h2, h2<=h1, h1<=x);
- set p = (k+1) mod NCH;
- go to SUM.
REQ-018 SUM: out_data SHALL be registered as P1 + P2, zero-extended to W+2 bits (unsigned, no overflow possible). out_ch SHALL be registered as k. The FSM then goes to OUT.
REQ-019 OUT: out_valid SHALL be high. out_data and out_ch SHALL be held stable until out_valid && out_ready, then the FSM returns to IDLE.
REQ-020 Latency SHALL be: accept at cycle t, out_valid first high at cycle t+2. Peak throughput is one result per 3 cycles.
REQ-021 in_ready SHALL be low in SUM and OUT. Channels not granted keep their samples pending; the block never drops an unaccepted sample.
REQ-022 Untouched channels' histories SHALL NOT change.
REQ-023 Flush SHALL act in any state, with priority over the handshake:
- next cycle: all histories = 0, FSM = IDLE, out_valid = 0;
- p is unchanged;
- no sample is accepted in a flush cycle.

Reset
REQ-024 Reset SHALL take priority over flush.
REQ-025 Reset SHALL clear:
- FSM to IDLE;
- p = 0;
- all histories, P1, P2, out_data, out_ch = 0;
- out_valid = 0, in_ready = 0 on the following cycle.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight result with no out_valid pulse.

Structure
REQ-027 A shared package fir4_sched_pkg SHALL hold the FSM state enum and the default W/NCH constants.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, grant index, any-grant).
REQ-029 The history storage, pair adders and FSM SHALL reside in fir4_channel_scheduler.

Verification
REQ-030 Single channel: ch0 sends 1, 2, 3, 4, 5 with out_ready=1 -> out_data 1, 3, 6, 10, 14, each 2 cycles after its accept, out_ch=0.
REQ-031 All four channels valid continuously, each with a constant sample equal to its channel index+1 -> grants 0, 1, 2, 3, 0, ...; the first results per channel are 1, 2, 3, 4.
REQ-032 Interleaved isolation: ch0 sends 10, ch1 sends 100, ch0 sends 20 -> ch0's second result is 30, not 130.
REQ-033 Backpressure: out_ready=0 for 5 cycles in OUT -> out_data/out_ch stable, in_ready all 0; the first cycle with out_ready=1 completes, next accept occurs in IDLE.
REQ-034 Max value: ch2 sends 0xFFFF four times (W=16) -> final out_data = 0x3FFFC.
REQ-035 Flush in OUT with ch1 history {7,7,7} -> out_valid drops next cycle; ch1's next sample 5 yields 5. Reset in SUM -> no out_valid; p = 0.

Source files
------------

// File: rtl/fir4_sched_pkg.sv
// rtl/fir4_sched_pkg.sv - shared defaults and FSM state type for the 4-tap channel scheduler
package fir4_sched_pkg;

    localparam int DEF_W   = 16;
    localparam int DEF_NCH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker: first requester at or above ptr_i, wrapping
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  gnt_idx_o,
    output logic           any_gnt_o
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        idx       = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % NCH;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx[IW-1:0];
                any_gnt_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir4_channel_scheduler.sv
// rtl/fir4_channel_scheduler.sv - time-shared 4-tap moving-sum filter over NCH channels
module fir4_channel_scheduler
    import fir4_sched_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int NCH = DEF_NCH,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [NCH-1:0]      in_valid,
    input  logic [NCH-1:0][W-1:0] in_data,
    output logic [NCH-1:0]      in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W+1:0]        out_data,
    output logic [CW-1:0]       out_ch
);

    state_e         state_q, state_d;
    logic [CW-1:0]  ptr_q;
    logic [CW-1:0]  k_q;
    logic [W-1:0]   h1_q [NCH];
    logic [W-1:0]   h2_q [NCH];
    logic [W-1:0]   h3_q [NCH];
    logic [W:0]     p1_q, p2_q;
    logic [W+1:0]   out_data_q;
    logic [CW-1:0]  out_ch_q;

    logic [NCH-1:0] gnt;
    logic [CW-1:0]  gnt_idx;
    logic           any_gnt;
    logic           accept;

    rr_arbiter #(.NCH(NCH), .IW(CW)) u_arb (
        .req_i     (in_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    // Flush and reset both veto the accept in the same cycle they are seen.
    assign accept    = (state_q == ST_IDLE) && any_gnt && !flush && !reset;
    assign in_ready  = accept ? gnt : '0;
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_SUM;
            ST_SUM:  state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            k_q        <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            for (int c = 0; c < NCH; c++) begin
                h1_q[c] <= '0;
                h2_q[c] <= '0;
                h3_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (flush) begin
                for (int c = 0; c < NCH; c++) begin
                    h1_q[c] <= '0;
                    h2_q[c] <= '0;
                    h3_q[c] <= '0;
                end
            end else if (accept) begin
                p1_q          <= {1'b0, in_data[gnt_idx]} + {1'b0, h1_q[gnt_idx]};
                p2_q          <= {1'b0, h2_q[gnt_idx]} + {1'b0, h3_q[gnt_idx]};
                h3_q[gnt_idx] <= h2_q[gnt_idx];
                h2_q[gnt_idx] <= h1_q[gnt_idx];
                h1_q[gnt_idx] <= in_data[gnt_idx];
                k_q           <= gnt_idx;
                ptr_q         <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CW'(1);
            end
            if (state_q == ST_SUM && !flush) begin
                out_data_q <= {1'b0, p1_q} + {1'b0, p2_q};
                out_ch_q   <= k_q;
            end
        end
    end

endmodule

// File: tb/tb_fir4_channel_scheduler.sv
// tb/tb_fir4_channel_scheduler.sv - scoreboard bench for fir4_channel_scheduler
module tb_fir4_channel_scheduler;

    localparam int W   = 16;
    localparam int NCH = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 flush = 1'b0;
    logic [NCH-1:0]       in_valid = '0;
    logic [NCH-1:0][W-1:0] in_data = '0;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [W+1:0]         out_data;
    logic [1:0]           out_ch;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [W-1:0]  mh1 [NCH];
    logic [W-1:0]  mh2 [NCH];
    logic [W-1:0]  mh3 [NCH];
    int            mptr = 0;
    int            acc_cyc = 0;
    logic [W+1:0]  exp_d [$];
    int            exp_c [$];
    logic [W+1:0]  res_d [$];
    int            res_c [$];
    int            acc_log [$];

    fir4_channel_scheduler #(.W(W), .NCH(NCH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: predicts grants, sums and out_valid timing each cycle.
    logic [NCH-1:0] exp_rdy;
    logic           exp_ov;
    logic [W+1:0]   esum;
    int             mc, mk;
    initial begin
        for (int c = 0; c < NCH; c++) begin
            mh1[c] = '0; mh2[c] = '0; mh3[c] = '0;
        end
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int c = 0; c < NCH; c++) begin
                    mh1[c] = '0; mh2[c] = '0; mh3[c] = '0;
                end
                mptr = 0;
                exp_d.delete();
                exp_c.delete();
            end else begin
                exp_rdy = '0;
                mk = -1;
                if (exp_d.size() == 0 && !flush) begin
                    for (int i = 0; i < NCH; i++) begin
                        mc = (mptr + i) % NCH;
                        if (mk < 0 && in_valid[mc]) begin
                            mk = mc;
                            exp_rdy[mc] = 1'b1;
                        end
                    end
                end
                exp_ov = (exp_d.size() > 0) && (cyc >= acc_cyc + 2);
                checks++;
                if (in_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL in_ready @%0d: got %b, required %b", cyc, in_ready, exp_rdy);
                end
                checks++;
                if (out_valid !== exp_ov) begin
                    errors++;
                    $display("FAIL out_valid @%0d: got %b, required %b", cyc, out_valid, exp_ov);
                end
                if (flush) begin
                    for (int c = 0; c < NCH; c++) begin
                        mh1[c] = '0; mh2[c] = '0; mh3[c] = '0;
                    end
                    exp_d.delete();
                    exp_c.delete();
                end else begin
                    if (exp_ov) begin
                        checks++;
                        if (out_data !== exp_d[0] || int'(out_ch) != exp_c[0]) begin
                            errors++;
                            $display("FAIL out_data/out_ch @%0d: got %0h/%0d, required %0h/%0d",
                                     cyc, out_data, out_ch, exp_d[0], exp_c[0]);
                        end
                        if (out_ready) begin
                            res_d.push_back(out_data);
                            res_c.push_back(int'(out_ch));
                            void'(exp_d.pop_front());
                            void'(exp_c.pop_front());
                        end
                    end
                    if (mk >= 0) begin
                        esum = 18'(in_data[mk]) + 18'(mh1[mk]) + 18'(mh2[mk]) + 18'(mh3[mk]);
                        exp_d.push_back(esum);
                        exp_c.push_back(mk);
                        mh3[mk] = mh2[mk];
                        mh2[mk] = mh1[mk];
                        mh1[mk] = in_data[mk];
                        mptr = (mk + 1) % NCH;
                        acc_cyc = cyc;
                        acc_log.push_back(mk);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        res_d.delete();
        res_c.delete();
        acc_log.delete();
    endtask

    task automatic send(input int ch, input logic [W-1:0] v);
        int t;
        t = 0;
        in_valid[ch] = 1'b1;
        in_data[ch] = v;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready[ch] && t < 100);
        if (!in_ready[ch]) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: ch%0d never got in_ready, required within 100 cycles", ch);
        end
        @(posedge clk);
        #1 in_valid[ch] = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (res_d.size() < n && t < 300) begin
            @(posedge clk);
            #1 t++;
        end
        if (res_d.size() < n) begin
            errors++;
            checks++;
            $display("FAIL wait_results: got %0d results, required %0d", res_d.size(), n);
        end
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 20);
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL wait_out_valid: got out_valid=0, required 1 within 20 cycles");
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b, required 0000", in_ready); end
        checks++;
        if (out_data !== 18'h0) begin errors++; $display("FAIL reset_out_data: got %0h, required 0", out_data); end
        checks++;
        if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_ch: got %0d, required 0", out_ch); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_channel();
        int exp_vals [5] = '{1, 3, 6, 10, 14};
        do_reset();
        for (int i = 1; i <= 5; i++) send(0, 16'(i));
        wait_results(5);
        for (int i = 0; i < 5 && i < res_d.size(); i++) begin
            checks++;
            if (res_d[i] !== 18'(exp_vals[i]) || res_c[i] != 0) begin
                errors++;
                $display("FAIL single_ch[%0d]: got %0d ch%0d, required %0d ch0", i, res_d[i], res_c[i], exp_vals[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int t;
        do_reset();
        for (int c = 0; c < NCH; c++) in_data[c] = 16'(c + 1);
        in_valid = 4'hF;
        t = 0;
        while (acc_log.size() < 8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 in_valid = '0;
        wait_results(8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++) begin
            checks++;
            if (acc_log[i] != i % NCH) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got ch%0d, required ch%0d", i, acc_log[i], i % NCH);
            end
        end
        for (int i = 0; i < 4 && i < res_d.size(); i++) begin
            checks++;
            if (res_d[i] !== 18'(i + 1) || res_c[i] != i) begin
                errors++;
                $display("FAIL rr_first[%0d]: got %0d ch%0d, required %0d ch%0d", i, res_d[i], res_c[i], i + 1, i);
            end
        end
    endtask

    task automatic test_isolation();
        do_reset();
        send(0, 16'd10);
        send(1, 16'd100);
        send(0, 16'd20);
        wait_results(3);
        if (res_d.size() >= 3) begin
            checks++;
            if (res_d[1] !== 18'd100 || res_c[1] != 1) begin
                errors++;
                $display("FAIL iso_ch1: got %0d ch%0d, required 100 ch1", res_d[1], res_c[1]);
            end
            checks++;
            if (res_d[2] !== 18'd30 || res_c[2] != 0) begin
                errors++;
                $display("FAIL iso_ch0: got %0d ch%0d, required 30 ch0", res_d[2], res_c[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        send(3, 16'd9);
        in_data[0] = 16'd7;
        in_valid[0] = 1'b1;
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_data !== 18'd9 || out_ch !== 2'd3 || in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got data=%0d ch=%0d rdy=%b, required 9 3 0000", i, out_data, out_ch, in_ready);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_release_rdy: got %b, required 0000", in_ready); end
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_accept: got %b, required 0001", in_ready); end
        @(posedge clk);
        #1 in_valid = '0;
        wait_results(2);
        if (res_d.size() >= 2) begin
            checks++;
            if (res_d[0] !== 18'd9 || res_d[1] !== 18'd7) begin
                errors++;
                $display("FAIL bp_results: got %0d,%0d, required 9,7", res_d[0], res_d[1]);
            end
        end
    endtask

    task automatic test_max_value();
        do_reset();
        for (int i = 0; i < 4; i++) send(2, 16'hFFFF);
        wait_results(4);
        if (res_d.size() >= 4) begin
            checks++;
            if (res_d[3] !== 18'h3FFFC || res_c[3] != 2) begin
                errors++;
                $display("FAIL max_value: got %0h ch%0d, required 3fffc ch2", res_d[3], res_c[3]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) send(1, 16'd7);
        wait_results(3);
        out_ready = 1'b0;
        send(1, 16'd7);
        wait_out_valid();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(1, 16'd5);
        wait_results(4);
        if (res_d.size() >= 4) begin
            checks++;
            if (res_d[3] !== 18'd5 || res_c[3] != 1) begin
                errors++;
                $display("FAIL flush_history: got %0d ch%0d, required 5 ch1", res_d[3], res_c[3]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ov_seen;
        do_reset();
        send(1, 16'd3);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        ov_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        checks++;
        if (ov_seen != 0) begin errors++; $display("FAIL reset_mid_ov: got %0d out_valid cycles, required 0", ov_seen); end
        @(posedge clk);
        #1;
        in_data[0] = 16'd1;
        in_data[3] = 16'd2;
        in_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_mid_ptr: got %b, required 0001", in_ready); end
        @(posedge clk);
        #1 in_valid = '0;
        res_d.delete();
        res_c.delete();
        wait_results(1);
        if (res_d.size() >= 1) begin
            checks++;
            if (res_d[0] !== 18'd1 || res_c[0] != 0) begin
                errors++;
                $display("FAIL reset_mid_result: got %0d ch%0d, required 1 ch0", res_d[0], res_c[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_isolation();
        test_backpressure();
        test_max_value();
        test_flush();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
